ej32_div: RTL and testbench
===========================

// Module: ej32_div
// PURPOSE
//  Iterative signed divider. Responds to the idiv/irem request that the arithmetic unit issues in phase 0.
//  - Holds div_bsy high while it computes, so the arithmetic unit stalls its phase-1 DROP.
//  - Returns quotient and remainder with Java int semantics.
//  - Sits beside the arithmetic unit; control routes div_q/div_r to TOS.
// PARAMETERS
//  DSZ  32  operand/result width in bits
//  BPC  1   quotient bits retired per CALC cycle; legal values 1, 2; DSZ % BPC == 0
// PORTS
//  clk      in   1    system clock, rising edge
//  rst      in   1    asynchronous, active-low reset (asserted when 0)
//  div_en   in   1    start request; sampled on clk; honoured only when div_bsy==0
//  div_s    in   DSZ  dividend (NOS), signed
//  div_t    in   DSZ  divisor (TOS), signed
//  div_bsy  out  1    high while an operation is in flight
//  div_done out  1    one-cycle pulse when results become valid
//  div_by0  out  1    last operation had divisor 0; held until next accepted start
//  div_q    out  DSZ  quotient, truncated toward zero
//  div_r    out  DSZ  remainder, sign of dividend
// BEHAVIOUR
//  Reset: state=IDLE; div_bsy=0, div_done=0, div_by0=0, div_q=0, div_r=0; clears all internal registers.
//  FSM states: IDLE -> CALC -> FIX -> IDLE.
//   - IDLE: on div_en at edge N, latch the operands.
//     - Latch |div_s| and |div_t| as DSZ-bit unsigned values, so |MIN_INT| = 2^(DSZ-1) is exact.
//     - Latch sq = sign(s)^sign(t) and sr = sign(s).
//     - Clear the partial remainder; load counter = DSZ/BPC; set div_bsy=1 after edge N.
//   - CALC: per cycle, BPC restoring steps.
//     - {rem,quo} <<= 1; if rem >= divisor then rem -= divisor, quo[0] = 1.
//     - Use a DSZ+1-bit subtractor.
//     - Counter decrements; leave for FIX when the counter reaches 1 at the edge.
//   - FIX: div_q = sq ? -quo : quo; div_r = sr ? -rem : rem; both DSZ-bit, wrap allowed.
//     - div_done=1 for this edge's output; div_bsy=0 after the FIX edge.
//  Latency: div_bsy high exactly DSZ/BPC+1 cycles (33 at defaults); results valid in the cycle div_done is high.
//  div_q/div_r/div_by0 hold until the next accepted start, then go to 0 while div_bsy is high.
//  div_en while div_bsy==1: ignored, with no effect on state or operands.
//  div_en in the same cycle as FIX: ignored (div_bsy still 1); a new start is accepted the following cycle.
//  Divide by zero: runs full latency; div_q = all ones (-1), div_r = div_s, div_by0 = 1.
//  MIN_INT / -1: div_q = MIN_INT (wraps), div_r = 0, div_by0 = 0.
//  Operand inputs are don't-care except at the accepting edge.
//  Reset mid-operation: immediate return to IDLE with reset values; no div_done pulse.
// CONFIGURATION
//  EJ32_DIV_SHORTCUT_EN defined: early-out when, at the accepting edge, div_t==0 or |div_s| < |div_t|.
//   - FSM skips CALC and goes IDLE -> FIX.
//   - div_bsy high 1 cycle.
//   - Results: q=0, r=div_s (div_t==0 keeps q=-1, r=div_s, div_by0=1).
//  EJ32_DIV_SHORTCUT_EN undefined: all operations take DSZ/BPC+1 cycles.
//   - Results are identical either way; only latency differs.
// TESTING
//  T1 s=100, t=7, pulse div_en -> div_bsy high 33 cycles; div_done; q=14, r=2.
//  T2 sign cases, expected (q,r):
//   - s=-7, t=2  -> (-3,-1)
//   - s=7,  t=-2 -> (-3, 1)
//   - s=-7, t=-2 -> (3, -1)
//  T3 s=0x80000000, t=-1 -> q=0x80000000, r=0, div_by0=0; s=5, t=0 -> q=0xFFFFFFFF, r=5, div_by0=1.
//  T4 start s=100,t=7; at cycle 10 assert div_en with s=9,t=3 -> ignored; result still q=14, r=2; next start accepted.
//  T5 rst low at cycle 15 of an operation -> all outputs 0 asynchronously, no div_done; after release, s=20,t=6 -> q=3, r=2.
//  T6 BPC=2 build: s=1000, t=10 -> div_bsy 17 cycles, q=100, r=0.
//   - With EJ32_DIV_SHORTCUT_EN: s=3, t=9 -> div_bsy 1 cycle, q=0, r=3.

Source files
------------

// File: rtl/ej32_div.sv
// Iterative signed divider (Java idiv/irem), restoring, BPC quotient bits per cycle, DSZ/BPC+1 cycle latency.
// Optional early-out for a zero divisor or |dividend| < |divisor| when EJ32_DIV_SHORTCUT_EN is defined.
module ej32_div #(
  parameter int DSZ = 32,
  parameter int BPC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           div_en,
  input  logic [DSZ-1:0] div_s,
  input  logic [DSZ-1:0] div_t,
  output logic           div_bsy,
  output logic           div_done,
  output logic           div_by0,
  output logic [DSZ-1:0] div_q,
  output logic [DSZ-1:0] div_r
);

  localparam int NSTEP = DSZ / BPC;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(NSTEP);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DSZ-1:0] quo_q, quo_d;
  logic [DSZ-1:0] rem_q, rem_d;
  logic [DSZ-1:0] dvs_q, dvs_d;
  logic           sq_q, sq_d;
  logic           sr_q, sr_d;
  logic           zdiv_q, zdiv_d;
  logic [DSZ-1:0] qo_q, qo_d;
  logic [DSZ-1:0] ro_q, ro_d;
  logic           bz_q, bz_d;
  logic           done_q, done_d;

  logic [DSZ-1:0] s_abs, t_abs;
  logic [DSZ-1:0] st_rem, st_quo;
  logic [DSZ:0]   trial;

  // Unsigned magnitudes are DSZ bits wide so |MIN_INT| is exact.
  assign s_abs = div_s[DSZ-1] ? -div_s : div_s;
  assign t_abs = div_t[DSZ-1] ? -div_t : div_t;

  // BPC chained restoring steps; the shifted remainder needs DSZ+1 bits.
  always_comb begin
    st_rem = rem_q;
    st_quo = quo_q;
    trial  = '0;
    for (int i = 0; i < BPC; i++) begin
      trial = {st_rem, st_quo[DSZ-1]} - {1'b0, dvs_q};
      if (!trial[DSZ]) begin
        st_rem = trial[DSZ-1:0];
        st_quo = {st_quo[DSZ-2:0], 1'b1};
      end else begin
        st_rem = {st_rem[DSZ-2:0], st_quo[DSZ-1]};
        st_quo = {st_quo[DSZ-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    zdiv_d  = zdiv_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_en) begin
          dvs_d   = t_abs;
          quo_d   = s_abs;
          rem_d   = '0;
          sq_d    = div_s[DSZ-1] ^ div_t[DSZ-1];
          sr_d    = div_s[DSZ-1];
          zdiv_d  = (div_t == '0);
          cnt_d   = CNT_INIT;
          qo_d    = '0;
          ro_d    = '0;
          bz_d    = 1'b0;
          state_d = CALC;
`ifdef EJ32_DIV_SHORTCUT_EN
          if ((div_t == '0) || (s_abs < t_abs)) begin
            quo_d   = '0;
            rem_d   = s_abs;
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        quo_d = st_quo;
        rem_d = st_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves quo all ones; the sign fix must not flip it.
        qo_d    = zdiv_q ? '1 : (sq_q ? -quo_q : quo_q);
        ro_d    = sr_q ? -rem_q : rem_q;
        bz_d    = zdiv_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      zdiv_q  <= 1'b0;
      qo_q    <= '0;
      ro_q    <= '0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      zdiv_q  <= zdiv_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
    end
  end

  assign div_bsy  = (state_q != IDLE);
  assign div_done = done_q;
  assign div_by0  = bz_q;
  assign div_q    = qo_q;
  assign div_r    = ro_q;

endmodule

// File: tb/tb_ej32_div.sv
// Bench for ej32_div: vector table and random ops through a scoreboard, plus busy/reset corner sequences and a BPC=2 instance.
module tb_ej32_div;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        div_en, en2;
  logic [31:0] div_s, div_t, s2, t2;
  logic        div_bsy, div_done, div_by0;
  logic        bsy2, done2, by02;
  logic [31:0] div_q, div_r, q2, r2;

  ej32_div #(.DSZ(32), .BPC(1)) dut (
    .clk(clk), .rst(rst), .div_en(div_en), .div_s(div_s), .div_t(div_t),
    .div_bsy(div_bsy), .div_done(div_done), .div_by0(div_by0),
    .div_q(div_q), .div_r(div_r)
  );

  ej32_div #(.DSZ(32), .BPC(2)) dut2 (
    .clk(clk), .rst(rst), .div_en(en2), .div_s(s2), .div_t(t2),
    .div_bsy(bsy2), .div_done(done2), .div_by0(by02),
    .div_q(q2), .div_r(r2)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] t;
    logic [31:0] q;
    logic [31:0] r;
    logic        by0;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        by0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int lat_of(input logic [31:0] s, input logic [31:0] t, input int bpc);
    longint as, at;
    bit     sc;
    as = longint'($signed(s));
    at = longint'($signed(t));
    if (as < 0) as = -as;
    if (at < 0) at = -at;
`ifdef EJ32_DIV_SHORTCUT_EN
    sc = 1'b1;
`else
    sc = 1'b0;
`endif
    if (sc && ((t == 32'd0) || (as < at))) return 1;
    return 32 / bpc + 1;
  endfunction

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic start_op(input vec_t v);
    exp_t e;
    e.q = v.q; e.r = v.r; e.by0 = v.by0; e.lat = lat_of(v.s, v.t, 1);
    div_en = 1'b1; div_s = v.s; div_t = v.t;
    sb.push_back(e);
    @(negedge clk);
    div_en = 1'b0; div_s = $urandom; div_t = $urandom;
    chk("bsy_set", div_bsy, 1);
    chk("busy_q_zero", div_q, 0);
    chk("busy_r_zero", div_r, 0);
  endtask

  task automatic finish_op(input int pre, input bit tail);
    int   cyc;
    exp_t e;
    cyc = pre;
    while (div_bsy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("done_pulse", div_done, 1);
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: actual=result required=no pending op");
    end else begin
      e = sb.pop_front();
      chk("latency", cyc, e.lat);
      chk("quotient", div_q, e.q);
      chk("remainder", div_r, e.r);
      chk("by0", div_by0, e.by0);
      if (tail) begin
        @(negedge clk);
        chk("done_low", div_done, 0);
        chk("q_hold", div_q, e.q);
      end
    end
  endtask

  task automatic op2(input vec_t v);
    int cyc;
    en2 = 1'b1; s2 = v.s; t2 = v.t;
    @(negedge clk);
    en2 = 1'b0; s2 = $urandom; t2 = $urandom;
    cyc = 0;
    while (bsy2 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("b2_latency", cyc, lat_of(v.s, v.t, 2));
    chk("b2_done", done2, 1);
    chk("b2_quotient", q2, v.q);
    chk("b2_remainder", r2, v.r);
    chk("b2_by0", by02, v.by0);
    @(negedge clk);
  endtask

  vec_t tbl[14];
  vec_t b2[5];

  initial begin
    vec_t v;
    int   si, ti;
    bit   seen;

    tbl[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    tbl[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    tbl[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
    tbl[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    tbl[5]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
    tbl[6]  = '{32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    tbl[7]  = '{32'd0,        32'd7,        32'd0,        32'd0,        1'b0};
    tbl[8]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0};
    tbl[9]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0};
    tbl[10] = '{32'd3,        32'd9,        32'd0,        32'd3,        1'b0};
    tbl[11] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0};
    tbl[12] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0};
    tbl[13] = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};

    b2[0] = '{32'd1000,       32'd10,       32'd100,      32'd0,        1'b0};
    b2[1] = '{32'd3,          32'd9,        32'd0,        32'd3,        1'b0};
    b2[2] = '{32'hFFFFFC17,   32'd10,       32'hFFFFFF9C, 32'hFFFFFFFF, 1'b0};
    b2[3] = '{32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    b2[4] = '{32'd7,          32'd0,        32'hFFFFFFFF, 32'd7,        1'b1};

    rst = 1'b0; div_en = 1'b0; div_s = '0; div_t = '0;
    en2 = 1'b0; s2 = '0; t2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_bsy", div_bsy, 0);
    chk("rst_done", div_done, 0);
    chk("rst_by0", div_by0, 0);
    chk("rst_q", div_q, 0);
    chk("rst_r", div_r, 0);
    chk("rst_b2_bsy", bsy2, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      start_op(tbl[i]);
      finish_op(0, 1'b1);
    end

    // Random operands against a behavioural model (avoids /0 and /-1).
    for (int k = 0; k < 16; k++) begin
      v.s = (k % 2 == 0) ? $urandom : 32'($urandom_range(0, 5000)) * ((k % 4 == 1) ? -1 : 1);
      v.t = (k % 3 == 0) ? $urandom : 32'($urandom_range(1, 300)) * ((k % 5 < 2) ? -1 : 1);
      if (v.t == 32'd0 || v.t == 32'hFFFFFFFF) v.t = 32'd3;
      si = v.s; ti = v.t;
      v.q = si / ti;
      v.r = si % ti;
      v.by0 = 1'b0;
      start_op(v);
      finish_op(0, 1'b1);
    end

    // Start requests while busy are ignored.
    start_op(tbl[0]);
    repeat (9) @(negedge clk);
    div_en = 1'b1; div_s = 32'd9; div_t = 32'd3;
    @(negedge clk);
    div_en = 1'b0;
    finish_op(10, 1'b1);
    start_op('{32'd9, 32'd3, 32'd3, 32'd0, 1'b0});
    finish_op(0, 1'b1);

    // div_en held through the FIX cycle: ignored there, accepted the cycle after.
    start_op(tbl[0]);
    div_en = 1'b1; div_s = 32'd9; div_t = 32'd3;
    finish_op(0, 1'b0);
    sb.push_back('{32'd3, 32'd0, 1'b0, lat_of(32'd9, 32'd3, 1)});
    @(negedge clk);
    div_en = 1'b0;
    chk("follow_bsy", div_bsy, 1);
    finish_op(0, 1'b1);

    // Reset mid-operation.
    start_op(tbl[0]);
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_bsy", div_bsy, 0);
    chk("arst_done", div_done, 0);
    chk("arst_q", div_q, 0);
    chk("arst_r", div_r, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = seen | div_done | div_bsy;
    end
    chk("no_done_after_rst", seen, 0);
    start_op('{32'd20, 32'd6, 32'd3, 32'd2, 1'b0});
    finish_op(0, 1'b1);

    foreach (b2[i]) op2(b2[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
